planificador_compuertas: RTL and testbench
==========================================

Name: planificador_compuertas

Overview:
Shares one 1-bit seven-gate logic bank (AND, NAND, OR, NOR, NOT, XOR, XNOR) between N_REQ requesters. A round-robin arbiter accepts one WIDTH-bit operation at a time and drives the shared gate bank bit-serially, LSB first, one bit per cycle. The finished word is returned on a valid/ready response channel tagged with the requester id. It sits between the requesting blocks and the gate bank, and is the only block that sequences that bank.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width in bits (>=2)
ID_W, $clog2(N_REQ), width of requester id

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  N_REQ  per-requester request valid
req_ready  output  N_REQ  per-requester grant/accept, at most one bit high
req_op  input  3*N_REQ  per-requester opcode, slice i = [3i+2:3i]
req_a  input  WIDTH*N_REQ  per-requester operand A
req_b  input  WIDTH*N_REQ  per-requester operand B
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_data  output  WIDTH  result word
rsp_id  output  ID_W  index of the requester served
rsp_err  output  1  illegal opcode flag
busy  output  1  high in EVAL or RESP

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low. While rst_n=0:
  - state=IDLE, rr pointer=0.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0.
- Opcodes: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 NOT(A) with B ignored, 5 XOR, 6 XNOR. Opcode 7 is illegal.
- FSM states: IDLE, EVAL, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from the rr pointer upward, modulo N_REQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0. req_ready is 0 in every other state.
  - Accept happens on a clock edge with req_valid[i] & req_ready[i]. On accept:
    - latch op, A, B and id;
    - clear the result register and the bit counter;
    - set rr pointer = winner+1 mod N_REQ;
    - go to EVAL.
  - If no request is valid, stay in IDLE; the pointer is unchanged.
- EVAL:
  - Each cycle, the gate bank is fed A[k] and B[k] for bit index k. result[k] <= gate(op, A[k], B[k]). k increments.
  - Exactly WIDTH cycles in EVAL. After the edge that writes bit WIDTH-1, go to RESP.
  - Illegal opcode still takes WIDTH cycles (uniform latency). The result is forced to 0 and the err flag is latched to 1.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_valid & rsp_ready on an edge, then return to IDLE.
  - rsp_ready=0 stalls indefinitely with all outputs stable.
- Latency: rsp_valid is first high in the cycle after the WIDTH-th edge following the accept edge.
- Throughput: one mandatory IDLE cycle between operations, so the minimum period is WIDTH+2 cycles with rsp_ready held at 1.
- busy = (state != IDLE).
- Payload rules:
  - Requesters must hold their payload stable while valid and not yet accepted.
  - Payload is sampled only on the accept edge; later changes have no effect.
  - Deasserting req_valid before grant is allowed; the pointer is unaffected.
- Reset mid-operation (EVAL or RESP): the transaction is dropped, no response is ever produced, and all state returns to reset values immediately.
- rsp_data and rsp_id retain their last values after the handshake; rsp_valid=0 qualifies them.

Test Plan:
1. Single op, N_REQ=4, WIDTH=8: req0 op=0, A=0xCC, B=0xAA.
   -> accepted immediately; rsp_valid high 8 edges after accept; rsp_data=0x88, rsp_id=0, rsp_err=0; busy high from the accept edge until the handshake.
2. All opcodes via req1 with A=0xCC, B=0xAA:
   -> op1 0x77, op2 0xEE, op3 0x11, op4 0x33, op5 0x66, op6 0x99; op7 gives 0x00 with rsp_err=1 and the same 8-cycle latency.
3. Round robin:
   - All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; req_ready is one-hot in IDLE and zero elsewhere; period 10 cycles.
   - Pointer=2 with only req0 and req3 valid -> req3 first, then req0.
4. Backpressure: rsp_ready=0 for 5 cycles in RESP.
   -> rsp_valid, rsp_data, rsp_id and rsp_err are stable; no req_ready asserted; handshake completes on the first edge with rsp_ready=1.
5. Reset mid-EVAL: assert rst_n=0 after bit 3 is written.
   -> all outputs 0 asynchronously (before the next edge); after release, no response appears; with all requests valid, req0 is granted first.
6. Payload isolation: change req_a of the granted requester during EVAL, and change payload of an ungranted requester.
   -> the result reflects the accept-edge values; a later grant of the ungranted requester uses the values present at its own accept.

Source files
------------

// File: rtl/planificador_compuertas.sv
// Round-robin scheduler sharing one 1-bit seven-gate logic bank between N_REQ
// requesters; each accepted word is evaluated LSB first, one bit per cycle.
module planificador_compuertas #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} state_e;
    typedef enum logic [2:0] {
        OP_AND, OP_NAND, OP_OR, OP_NOR, OP_NOT, OP_XOR, OP_XNOR, OP_ILL
    } op_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   idx;
    logic              any_valid;
    logic              accept;
    logic [2:0]        winner_op;

    logic [2:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q, res_q, res_next;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [ID_W-1:0]   id_q;
    logic              err_q;
    logic              gate_bit;
    logic              last_bit;

    logic [WIDTH-1:0]  rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_err_q;

    // The shared 1-bit gate bank; the illegal opcode yields 0.
    function automatic logic gate(input logic [2:0] op, input logic a, input logic b);
        unique case (op_e'(op))
            OP_AND:  gate = a & b;
            OP_NAND: gate = ~(a & b);
            OP_OR:   gate = a | b;
            OP_NOR:  gate = ~(a | b);
            OP_NOT:  gate = ~a;
            OP_XOR:  gate = a ^ b;
            OP_XNOR: gate = ~(a ^ b);
            default: gate = 1'b0;
        endcase
    endfunction

    // First valid requester at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int j = 0; j < N_REQ; j++) begin
            idx = ID_W'((int'(rr_ptr_q) + j) % N_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

    assign winner_op = req_op[3*int'(winner) +: 3];
    assign gate_bit  = gate(op_q, a_q[bit_cnt_q], b_q[bit_cnt_q]);
    assign last_bit  = (bit_cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        res_next            = res_q;
        res_next[bit_cnt_q] = gate_bit;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        unique case (state_q)
            IDLE: if (any_valid) begin
                req_ready[winner] = 1'b1;
                accept            = 1'b1;
                state_d           = EVAL;
            end
            EVAL: if (last_bit) state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            bit_cnt_q  <= '0;
            id_q       <= '0;
            err_q      <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                op_q      <= winner_op;
                a_q       <= req_a[WIDTH*int'(winner) +: WIDTH];
                b_q       <= req_b[WIDTH*int'(winner) +: WIDTH];
                id_q      <= winner;
                err_q     <= (winner_op == 3'(OP_ILL));
                res_q     <= '0;
                bit_cnt_q <= '0;
                rr_ptr_q  <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
            end
            if (state_q == EVAL) begin
                res_q     <= res_next;
                bit_cnt_q <= bit_cnt_q + 1'b1;
                // Response registers are separate so they survive the next accept.
                if (last_bit) begin
                    rsp_data_q <= res_next;
                    rsp_id_q   <= id_q;
                    rsp_err_q  <= err_q;
                end
            end
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_planificador_compuertas.sv
// Scoreboard bench for planificador_compuertas: word-level reference model,
// directed scenarios, then randomized traffic with random backpressure.
module tb_planificador_compuertas;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid, req_ready;
    logic [3*N-1:0]   req_op;
    logic [W*N-1:0]   req_a, req_b;
    logic             rsp_valid, rsp_err, busy;
    logic             rsp_ready = 1'b1;
    logic [W-1:0]     rsp_data;
    logic [IW-1:0]    rsp_id;

    logic [N-1:0]     valid_v = '0;
    logic [2:0]       op_v [N];
    logic [W-1:0]     a_v [N];
    logic [W-1:0]     b_v [N];

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       err;
    } rsp_t;

    rsp_t         sb_q [$];
    int           m_mode = 0;   // 0 free, 1 computing, 2 response pending
    int           m_cnt  = 0;
    int           m_ptr  = 0;
    logic [N-1:0] acc_seen = '0;
    int           cyc = 0;
    int           n_vec = 0;
    int           n_err = 0;

    planificador_compuertas #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign req_valid = valid_v;
    always_comb begin
        req_op = '0;
        req_a  = '0;
        req_b  = '0;
        for (int i = 0; i < N; i++) begin
            req_op[3*i +: 3] = op_v[i];
            req_a[W*i +: W]  = a_v[i];
            req_b[W*i +: W]  = b_v[i];
        end
    end

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int j = 0; j < N; j++) begin
            if (v[(ptr + j) % N]) return (ptr + j) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] ref_word(input logic [2:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (op)
            3'd0: return a & b;
            3'd1: return ~(a & b);
            3'd2: return a | b;
            3'd3: return ~(a | b);
            3'd4: return ~a;
            3'd5: return a ^ b;
            3'd6: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: advances on each edge, pushes expected responses on accept.
    initial begin
        int   w;
        rsp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_mode   = 0;
                m_cnt    = 0;
                m_ptr    = 0;
                acc_seen = '0;
                sb_q.delete();
            end else begin
                acc_seen = '0;
                case (m_mode)
                    0: begin
                        w = pick(valid_v, m_ptr);
                        if (w >= 0) begin
                            e.id   = w;
                            e.data = ref_word(op_v[w], a_v[w], b_v[w]);
                            e.err  = (op_v[w] == 3'd7);
                            sb_q.push_back(e);
                            acc_seen[w] = 1'b1;
                            m_ptr  = (w + 1) % N;
                            m_mode = 1;
                            m_cnt  = 0;
                        end
                    end
                    1: begin
                        m_cnt++;
                        if (m_cnt == W) m_mode = 2;
                    end
                    default: if (rsp_ready) begin
                        void'(sb_q.pop_front());
                        m_mode = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: compares every DUT output against the model on the falling edge.
    initial begin
        int           w;
        logic [N-1:0] exp_rdy;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_req_ready", 64'(req_ready), 64'(0));
                check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                check("rst_rsp_data",  64'(rsp_data),  64'(0));
                check("rst_rsp_id",    64'(rsp_id),    64'(0));
                check("rst_rsp_err",   64'(rsp_err),   64'(0));
                check("rst_busy",      64'(busy),      64'(0));
            end else begin
                exp_rdy = '0;
                if (m_mode == 0) begin
                    w = pick(valid_v, m_ptr);
                    if (w >= 0) exp_rdy[w] = 1'b1;
                end
                check("req_ready", 64'(req_ready), 64'(exp_rdy));
                check("busy",      64'(busy),      64'(m_mode != 0));
                check("rsp_valid", 64'(rsp_valid), 64'(m_mode == 2));
                if (m_mode == 2 && rsp_valid) begin
                    if (sb_q.size() == 0) begin
                        check("sb_empty", 64'(0), 64'(1));
                    end else begin
                        check("sb_data", 64'(rsp_data), 64'(sb_q[0].data));
                        check("sb_id",   64'(rsp_id),   64'(sb_q[0].id));
                        check("sb_err",  64'(rsp_err),  64'(sb_q[0].err));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, wanted completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_acc(input int id);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!acc_seen[id] && n < 100);
        if (!acc_seen[id]) check("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic issue(input int id, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        op_v[id]    = op;
        a_v[id]     = a;
        b_v[id]     = b;
        valid_v[id] = 1'b1;
        wait_acc(id);
        valid_v[id] = 1'b0;
    endtask

    // Waits for a response, checks it against constants, then completes the handshake.
    task automatic wait_rsp(input string name, input int id, input logic [W-1:0] data,
                            input logic err, output int at_cyc);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 64'(rsp_valid), 64'(1));
        check({name, "_data"}, 64'(rsp_data), 64'(data));
        check({name, "_id"},   64'(rsp_id),   64'(id));
        check({name, "_err"},  64'(rsp_err),  64'(err));
        at_cyc = cyc;
        if (rsp_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic op_test(input string name, input int id, input logic [2:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] data, input logic err);
        int n = 0;
        issue(id, op, a, b);
        while (!rsp_valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(W));
        check({name, "_data"}, 64'(rsp_data), 64'(data));
        check({name, "_id"},   64'(rsp_id),   64'(id));
        check({name, "_err"},  64'(rsp_err),  64'(err));
        @(posedge clk);
        #1;
        check({name, "_done"}, 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        int              t, t_prev;
        logic [W-1:0]    cap_data;
        logic [W-1:0]    op_exp [8];
        int              rr_ids [5];

        op_exp = '{8'h88, 8'h77, 8'hEE, 8'h11, 8'h33, 8'h66, 8'h99, 8'h00};
        rr_ids = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            op_v[i] = '0;
            a_v[i]  = '0;
            b_v[i]  = '0;
        end

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single AND on requester 0, then every opcode on requester 1.
        op_test("op0_req0", 0, 3'd0, 8'hCC, 8'hAA, op_exp[0], 1'b0);
        for (int op = 1; op < 8; op++) begin
            op_test($sformatf("op%0d_req1", op), 1, 3'(op), 8'hCC, 8'hAA, op_exp[op], op == 7);
        end

        // Pointer now at 2: with req0 and req3 pending, req3 wins first.
        op_v[0] = 3'd6; a_v[0] = 8'hF0; b_v[0] = 8'hFF;
        op_v[3] = 3'd2; a_v[3] = 8'h30; b_v[3] = 8'h0C;
        valid_v[0] = 1'b1;
        valid_v[3] = 1'b1;
        wait_acc(3);
        valid_v[3] = 1'b0;
        wait_rsp("rr_wrap_first", 3, 8'h3C, 1'b0, t);
        wait_acc(0);
        valid_v[0] = 1'b0;
        wait_rsp("rr_wrap_second", 0, 8'hF0, 1'b0, t);

        // Backpressure: response held stable with another requester waiting.
        rsp_ready = 1'b0;
        issue(2, 3'd3, 8'h5A, 8'h0F);
        op_v[1] = 3'd4; a_v[1] = 8'h3C; b_v[1] = 8'h55;
        valid_v[1] = 1'b1;
        wait_rsp("bp_first", 2, 8'hA0, 1'b0, t);
        cap_data = rsp_data;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid",     64'(rsp_valid), 64'(1));
            check("bp_data",      64'(rsp_data),  64'(cap_data));
            check("bp_id",        64'(rsp_id),    64'(2));
            check("bp_req_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_handshake", 64'(rsp_valid), 64'(0));
        wait_acc(1);
        valid_v[1] = 1'b0;
        wait_rsp("bp_next", 1, 8'hC3, 1'b0, t);

        // Payload isolation for the granted and an ungranted requester.
        issue(1, 3'd5, 8'h0F, 8'h33);
        a_v[1] = 8'hFF; b_v[1] = 8'h00; op_v[1] = 3'd7;
        a_v[2] = 8'h11; op_v[2] = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        a_v[2] = 8'hF0; b_v[2] = 8'h3C; op_v[2] = 3'd0;
        valid_v[2] = 1'b1;
        wait_rsp("iso_granted", 1, 8'h3C, 1'b0, t);
        wait_acc(2);
        valid_v[2] = 1'b0;
        wait_rsp("iso_later", 2, 8'h30, 1'b0, t);

        // Reset after bit 3 is written; outputs must clear before the next edge.
        issue(2, 3'd2, 8'hAA, 8'h55);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy",      64'(busy),      64'(0));
        check("async_rsp_valid", 64'(rsp_valid), 64'(0));
        check("async_rsp_data",  64'(rsp_data),  64'(0));
        check("async_rsp_id",    64'(rsp_id),    64'(0));
        check("async_req_ready", 64'(req_ready), 64'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("no_rsp_after_reset", 64'(rsp_valid), 64'(0));
        end

        // All four valid after reset: grants 0,1,2,3,0 every W+2 cycles.
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            op_v[i] = 3'(i);
            a_v[i]  = 8'hCC;
            b_v[i]  = 8'hAA;
        end
        valid_v = '1;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_rsp($sformatf("rr_all_%0d", k), rr_ids[k], op_exp[rr_ids[k]], 1'b0, t);
            if (k > 0) check("rr_period", 64'(t - t_prev), 64'(W + 2));
            t_prev = t;
        end
        valid_v = '0;

        // Randomized traffic with withdrawals and random backpressure.
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (valid_v[i] && acc_seen[i]) begin
                    valid_v[i] = 1'b0;
                    a_v[i]     = W'($urandom);
                    b_v[i]     = W'($urandom);
                end else if (!valid_v[i] && $urandom_range(0, 3) == 0) begin
                    op_v[i]    = 3'($urandom_range(0, 7));
                    a_v[i]     = W'($urandom);
                    b_v[i]     = W'($urandom);
                    valid_v[i] = 1'b1;
                end else if (valid_v[i] && $urandom_range(0, 31) == 0) begin
                    valid_v[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end

        valid_v   = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && (m_mode != 0 || sb_q.size() != 0); c++) begin
            @(posedge clk);
            #1;
        end
        check("drain_idle", 64'(busy), 64'(0));
        check("drain_sb",   64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
